id_stage_q: RTL

ID_STAGE_Q -- requirements
Module: id_stage_q

---
 rtl/id_stage_q.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_q.sv
// Instruction-decode stage with a small instruction queue in front of a registered
// decode output. It interlocks one cycle on load-use and holds in a trap state until redirected.
module id_stage_q #(
  parameter int unsigned DEPTH          = 4,
  parameter logic [31:0] MTVEC_BASE     = 32'h0000_0F40,
  parameter bit          LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_wen_o,
  output logic [31:0] base_addr_o,
  output logic [31:0] offset_addr_o,
  output logic        mem_rd_req_o,
  output logic [31:0] mem_rd_addr_o,
  output logic        illegal_o,
  output logic        trap_o,
  output logic [31:0] mepc_o,
  output logic [5:0]  mcause_o,
  output logic [31:0] mtvec_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_TRAP} state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        reg_wen;
    logic [31:0] base;
    logic [31:0] offset;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        illegal;
    logic        trap;
    logic [31:0] mepc;
    logic [5:0]  mcause;
    logic [31:0] mtvec;
  } out_t;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  out_t          out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [4:0]    last_rd_q, last_rd_d;
  logic [63:0]   mem_q [DEPTH];

  logic        empty, full, push, issue, hit;
  logic [31:0] head_inst, head_pc;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        legal, use_rs1, use_rs2;
  out_t        dec;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign in_ready = !full && !flush_i;
  assign push     = in_valid && in_ready;

  // NOTE: queue storage carries no reset; only pointers and count qualify its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {inst_i, inst_addr_i};
  end

  assign head_inst  = mem_q[rd_ptr_q][63:32];
  assign head_pc    = mem_q[rd_ptr_q][31:0];
  assign rs1_addr_o = head_inst[19:15];
  assign rs2_addr_o = head_inst[24:20];
  assign opcode     = head_inst[6:0];
  assign rd         = head_inst[11:7];
  assign funct3     = head_inst[14:12];
  assign funct7     = head_inst[31:25];
  assign imm_i      = {{20{head_inst[31]}}, head_inst[31:20]};
  assign imm_s      = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
  assign imm_b      = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                       head_inst[11:8], 1'b0};
  assign imm_j      = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                       head_inst[30:21], 1'b0};
  assign imm_u      = {head_inst[31:12], 12'b0};

  // NOTE: every decode output gets a default first so no path leaves a latch behind.
  always_comb begin
    dec      = '0;
    dec.inst = head_inst;
    dec.addr = head_pc;
    legal    = 1'b1;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OP_IMM: begin
        use_rs1     = 1'b1;
        dec.reg_wen = 1'b1;
        dec.rd      = rd;
        dec.op1     = rs1_data_i;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.op2 = {27'b0, head_inst[24:20]};
          legal   = (funct7 == 7'b0) || (funct3 == 3'b101 && funct7 == 7'b0100000);
        end else begin
          dec.op2 = imm_i;
        end
      end
      OP_REG: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec.reg_wen = 1'b1;
        dec.rd      = rd;
        dec.op1     = rs1_data_i;
        dec.op2     = rs2_data_i;
        legal       = (funct7 == 7'b0) || (funct7 == 7'b0000001) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_LOAD: begin
        use_rs1         = 1'b1;
        dec.reg_wen     = 1'b1;
        dec.rd          = rd;
        dec.op1         = rs1_data_i;
        dec.op2         = imm_i;
        dec.mem_rd_req  = 1'b1;
        dec.mem_rd_addr = rs1_data_i + imm_i;
        legal           = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OP_STORE: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.op1    = rs1_data_i;
        dec.op2    = rs2_data_i;
        dec.base   = rs1_data_i;
        dec.offset = imm_s;
        legal      = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.op1    = rs1_data_i;
        dec.op2    = rs2_data_i;
        dec.base   = head_pc;
        dec.offset = imm_b;
        legal      = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_JAL: begin
        dec.reg_wen = 1'b1;
        dec.rd      = rd;
        dec.op1     = head_pc;
        dec.op2     = 32'd4;
        dec.base    = head_pc;
        dec.offset  = imm_j;
      end
      OP_JALR: begin
        use_rs1     = 1'b1;
        dec.reg_wen = 1'b1;
        dec.rd      = rd;
        dec.op1     = head_pc;
        dec.op2     = 32'd4;
        dec.base    = rs1_data_i;
        dec.offset  = imm_i;
        legal       = (funct3 == 3'b000);
      end
      OP_LUI: begin
        dec.reg_wen = 1'b1;
        dec.rd      = rd;
        dec.op1     = imm_u;
      end
      OP_AUIPC: begin
        dec.reg_wen = 1'b1;
        dec.rd      = rd;
        dec.op1     = imm_u;
        dec.op2     = head_pc;
      end
      OP_SYSTEM: begin
        if (head_inst == 32'h0000_0073 || head_inst == 32'h0010_0073) begin
          dec.trap   = 1'b1;
          dec.mcause = head_inst[20] ? 6'd3 : 6'd11;
          dec.mepc   = head_pc;
          dec.mtvec  = MTVEC_BASE;
          dec.base   = head_pc;
          dec.offset = MTVEC_BASE - head_pc;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.inst    = head_inst;
      dec.addr    = head_pc;
      dec.illegal = 1'b1;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
    end
  end

  assign hit = LOAD_USE_STALL && (state_q == ST_RUN) && !empty && (last_rd_q != 5'd0) &&
               ((use_rs1 && rs1_addr_o == last_rd_q) || (use_rs2 && rs2_addr_o == last_rd_q));

  // The cycle spent in STALL is the bubble; the head may issue at its end.
  assign issue = !flush_i && !empty && (state_q != ST_TRAP) && !hit &&
                 (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    last_rd_d   = last_rd_q;
    if (flush_i) begin
      state_d     = ST_RUN;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      last_rd_d   = 5'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (issue) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, issue})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (issue) begin
        out_d       = dec;
        out_valid_d = 1'b1;
        last_rd_d   = dec.mem_rd_req ? dec.rd : 5'd0;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        ST_RUN: begin
          if (hit) begin
            state_d   = ST_STALL;
            last_rd_d = 5'd0;
          end else if (issue && dec.trap) begin
            state_d = ST_TRAP;
          end
        end
        ST_STALL: state_d = (issue && dec.trap) ? ST_TRAP : ST_RUN;
        default:  state_d = ST_TRAP;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      last_rd_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_rd_q   <= last_rd_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign inst_o        = out_q.inst;
  assign inst_addr_o   = out_q.addr;
  assign op1_o         = out_q.op1;
  assign op2_o         = out_q.op2;
  assign rd_addr_o     = out_q.rd;
  assign reg_wen_o     = out_q.reg_wen;
  assign base_addr_o   = out_q.base;
  assign offset_addr_o = out_q.offset;
  assign mem_rd_req_o  = out_q.mem_rd_req;
  assign mem_rd_addr_o = out_q.mem_rd_addr;
  assign illegal_o     = out_q.illegal;
  assign trap_o        = out_q.trap;
  assign mepc_o        = out_q.mepc;
  assign mcause_o      = out_q.mcause;
  assign mtvec_o       = out_q.mtvec;

endmodule
